scan_decoder: RTL
=================

SCAN_DECODER -- requirements
Module: scan_decoder

Interface
REQ-001 Parameter ADDR_W, default 5, code width; output width is 2**ADDR_W.
REQ-002 Parameter DWELL, default 15, cycles each code is held during a scan; legal range 1..65535.
REQ-003 clk  input  1  rising-edge clock; the block has one clock.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 en  input  1  direct-mode enable.
REQ-006 addr  input  ADDR_W  direct-mode code.
REQ-007 mode  input  1  0 = one-hot decode, 1 = thermometer decode.
REQ-008 scan_start  input  1  level-sampled request to sweep all codes.
REQ-009 scan_abort  input  1  terminate an active scan.
REQ-010 d  output  2**ADDR_W  registered decoded word.
REQ-011 cur_addr  output  ADDR_W  registered code currently driving d.
REQ-012 busy  output  1  high while in SCAN.
REQ-013 done  output  1  one-cycle pulse on scan completion.

Function
REQ-014 The FSM SHALL have two states: IDLE and SCAN.
REQ-015 Decode rule: one-hot sets only bit d[code]; thermometer sets d[i] = 1 for every i <= code.
REQ-016 IDLE, en=1: on the next edge, d <= decode(addr, mode) and cur_addr <= addr (latency 1 cycle).
REQ-017 IDLE, en=0: on the next edge, d <= 0 and cur_addr holds its value.
REQ-018 IDLE, scan_start=1, scan_abort=0: on the next edge the block enters SCAN with busy=1, cur_addr=0, d=decode(0, mode_latched) and dwell counter=0. This takes priority over en.
REQ-019 mode SHALL be latched at scan start; mode changes during SCAN have no effect until IDLE.
REQ-020 IDLE, scan_start=1 and scan_abort=1 together: abort wins, and the block behaves per REQ-016/017.
REQ-021 In SCAN, en, addr and scan_start SHALL be ignored.
REQ-022 SCAN, dwell counter < DWELL-1: the counter increments and d and cur_addr hold.
REQ-023 SCAN, dwell counter = DWELL-1 and cur_addr < 2**ADDR_W-1: cur_addr increments, d <= decode(new code) and the counter clears.
REQ-024 SCAN, dwell counter = DWELL-1 and cur_addr = 2**ADDR_W-1: the block returns to IDLE with busy=0, done=1 for exactly one cycle, d=0, and cur_addr held at all-ones.
REQ-025 Each code SHALL be presented for exactly DWELL cycles. A full scan lasts 2**ADDR_W * DWELL cycles from the first busy cycle. DWELL=1 advances every cycle.
REQ-026 scan_abort in SCAN: on the next edge the block returns to IDLE with busy=0, d=0, done=0 and cur_addr held.
REQ-027 The dwell counter SHALL be 16 bits wide. cur_addr SHALL NOT wrap past all-ones during a scan.
REQ-028 done SHALL be asserted only by REQ-024 and never while busy=1.

Reset
REQ-029 rst=1 at an edge SHALL force IDLE with d=0, cur_addr=0, busy=0, done=0 and dwell counter=0, overriding all other inputs.
REQ-030 rst asserted mid-scan SHALL abort the scan without a done pulse.
REQ-031 After rst deasserts, the first functional update occurs on the next edge.

Verification (ADDR_W=5, DWELL=15 unless stated)
REQ-032 Direct one-hot: rst, then en=1, mode=0, addr sweeps 0..31 one per cycle -> each cycle later d = 1<<addr and cur_addr = addr. Then en=0 -> d=0 with cur_addr held.
REQ-033 Direct thermometer: mode=1, addr=0 -> d=0x00000001; addr=7 -> d=0x000000FF; addr=31 -> d=0xFFFFFFFF.
REQ-034 Full scan: one-cycle scan_start with mode=0 -> busy high for 480 cycles, d = 1<<k for cycles 15k..15k+14, then done=1 for one cycle with busy=0, d=0 and cur_addr=31. Toggling mode, en and addr mid-scan has no effect.
REQ-035 DWELL=1, mode=1 full scan -> d steps 0x1, 0x3, 0x7 ... 0xFFFFFFFF on consecutive cycles, busy lasts 32 cycles, done follows.
REQ-036 Abort and priority: scan_abort at code 10, dwell 4 -> next cycle busy=0, d=0, done=0, cur_addr=10. Simultaneous scan_start+scan_abort in IDLE with en=1, addr=3 -> d=0x8 and busy stays 0.
REQ-037 Reset mid-scan at code 20 -> next cycle d=0, cur_addr=0, busy=0 and no done pulse. A later scan_start restarts the scan from code 0.

Source files
------------

// File: rtl/scan_decoder.sv
// -----------------------------------------------------------------------------
// scan_decoder
//
// Registered ADDR_W -> 2**ADDR_W decoder with two sources of code:
//   * direct mode : the code on addr is decoded whenever en is high.
//   * scan mode   : a request on scan_start sweeps every code 0..2**ADDR_W-1,
//                   holding each code for DWELL cycles, then pulses done.
// Each code decodes as either one-hot (mode=0) or thermometer (mode=1).
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   en         in   direct-mode enable
//   addr       in   direct-mode code            [ADDR_W]
//   mode       in   0 = one-hot, 1 = thermometer (latched at scan start)
//   scan_start in   level-sampled request to start a sweep
//   scan_abort in   terminate an active sweep (also vetoes scan_start)
//   d          out  registered decoded word     [2**ADDR_W]
//   cur_addr   out  code currently driving d    [ADDR_W]
//   busy       out  high while sweeping
//   done       out  one-cycle pulse when a sweep completes
// -----------------------------------------------------------------------------
module scan_decoder #(
  parameter int ADDR_W = 5,
  parameter int DWELL  = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [ADDR_W-1:0]      addr,
  input  logic                   mode,
  input  logic                   scan_start,
  input  logic                   scan_abort,
  output logic [2**ADDR_W-1:0]   d,
  output logic [ADDR_W-1:0]      cur_addr,
  output logic                   busy,
  output logic                   done
);

  localparam int          N          = 2**ADDR_W;
  localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  state_e              state_q;
  logic [N-1:0]        d_q;
  logic [ADDR_W-1:0]   cur_addr_q;
  logic [15:0]         dwell_q;
  logic                mode_q;
  logic                busy_q;
  logic                done_q;

  logic [ADDR_W-1:0]   next_addr_d;

  // Decode one code. Every bit of the result is written on every call, so
  // the function is purely combinational.
  function automatic logic [N-1:0] decode(input logic [ADDR_W-1:0] code,
                                          input logic              thermo);
    logic [N-1:0] w;
    w = '0;
    for (int i = 0; i < N; i++) begin
      w[i] = thermo ? (i <= int'(code)) : (i == int'(code));
    end
    return w;
  endfunction

  assign next_addr_d = cur_addr_q + ADDR_W'(1);

  // NOTE: every register below uses <= so all of them see the pre-edge
  // values of each other; blocking = here would chain updates within a cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      d_q        <= '0;
      cur_addr_q <= '0;
      dwell_q    <= '0;
      mode_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      // done is a pulse: only the final dwell cycle of a sweep raises it.
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // A start vetoed by a simultaneous abort falls through to direct mode.
          if (scan_start && !scan_abort) begin
            state_q    <= SCAN;
            busy_q     <= 1'b1;
            mode_q     <= mode;
            cur_addr_q <= '0;
            dwell_q    <= '0;
            d_q        <= decode('0, mode);
          end else if (en) begin
            cur_addr_q <= addr;
            d_q        <= decode(addr, mode);
          end else begin
            d_q        <= '0;
          end
        end

        SCAN: begin
          if (scan_abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            dwell_q <= '0;
            d_q     <= '0;
          end else if (dwell_q != DWELL_LAST) begin
            dwell_q <= dwell_q + 16'd1;
          end else if (&cur_addr_q) begin
            // Last code finished: cur_addr stays at all-ones, no wrap.
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            dwell_q <= '0;
            d_q     <= '0;
          end else begin
            cur_addr_q <= next_addr_d;
            dwell_q    <= '0;
            d_q        <= decode(next_addr_d, mode_q);
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign d        = d_q;
  assign cur_addr = cur_addr_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
